nes_pad_responder: RTL and testbench

- Device-side model of an NES controller: responds to the latch/clock strobes a console-side NES reader generates and shifts 8 button states out on the serial data line.
- Used to drive the `nes_in` pin in system simulation and on-board loopback. It pairs a host button vector (switches or test stimulus) with the existing NES input controller.
- Behaves like a 4021-based pad:
  - parallel load while latch is high;
  - serial shift on clock rising edges;
  - line reads "released" (high) after 8 bits.

---
 rtl/nes_pad_responder.sv | 165 ++++++++++++++++
 tb/tb_nes_pad_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_responder.sv
// Device-side NES pad model: answers latch/clock strobes from a console-side
// reader and shifts eight active-low button states out on nes_data.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset, line released, waiting for latch high
// ST_LOAD  | latch high, shift register continuously reloaded from buttons
// ST_SHIFT | latch low, one bit shifted per filtered nes_clk rising edge
// ST_DONE  | all 8 bits shifted, line released, clock edges ignored
module nes_pad_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  buttons_in,
  input  logic        nes_latch,
  input  logic        nes_clk,
  output logic        nes_data,
  output logic [3:0]  bit_index,
  output logic        read_done,
  output logic [15:0] read_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  // Filter counter terminal value: level flips on the FILTER_CYCLES-th
  // consecutive differing sample.
  localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] latch_sync_q, clk_sync_q;
  logic                   latch_filt_q, latch_filt_d, clk_filt_q, clk_filt_d;
  logic [3:0]             latch_cnt_q, latch_cnt_d, clk_cnt_q, clk_cnt_d;
  logic                   latch_prev_q, clk_prev_q;
  logic                   latch_rise, latch_fall, clk_rise;

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [3:0]  bit_index_q, bit_index_d;
  logic        read_done_q, read_done_d;
  logic [15:0] read_count_q, read_count_d;
  logic        nes_data_q;

  // Synchronizer chains, stability filters and edge-detect history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_filt_q <= 1'b0;
      clk_filt_q   <= 1'b0;
      latch_cnt_q  <= '0;
      clk_cnt_q    <= '0;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
      latch_filt_q <= latch_filt_d;
      clk_filt_q   <= clk_filt_d;
      latch_cnt_q  <= latch_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
      latch_prev_q <= latch_filt_q;
      clk_prev_q   <= clk_filt_q;
    end
  end

  // Filter next state: any sample matching the current level clears the run.
  always_comb begin
    latch_filt_d = latch_filt_q;
    latch_cnt_d  = '0;
    clk_filt_d   = clk_filt_q;
    clk_cnt_d    = '0;
    if (latch_sync_q[SYNC_STAGES-1] != latch_filt_q) begin
      if (latch_cnt_q == FILT_LAST) latch_filt_d = latch_sync_q[SYNC_STAGES-1];
      else                          latch_cnt_d  = latch_cnt_q + 4'd1;
    end
    if (clk_sync_q[SYNC_STAGES-1] != clk_filt_q) begin
      if (clk_cnt_q == FILT_LAST) clk_filt_d = clk_sync_q[SYNC_STAGES-1];
      else                        clk_cnt_d  = clk_cnt_q + 4'd1;
    end
  end

  assign latch_rise = latch_filt_q & ~latch_prev_q;
  assign latch_fall = ~latch_filt_q & latch_prev_q;
  assign clk_rise   = clk_filt_q & ~clk_prev_q;

  // Pad state, shift register and read bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sr_q         <= 8'hFF;
      bit_index_q  <= '0;
      read_done_q  <= 1'b0;
      read_count_q <= '0;
      nes_data_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_index_q  <= bit_index_d;
      read_done_q  <= read_done_d;
      read_count_q <= read_count_d;
      // Driven from the next shift-register MSB so the line moves in the
      // same cycle the register does.
      nes_data_q   <= sr_d[7];
    end
  end

  // Next-state logic; a latch rising edge outranks a same-cycle clock edge.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_index_d  = bit_index_q;
    read_done_d  = 1'b0;
    read_count_d = read_count_q;
    case (state_q)
      ST_IDLE: begin
        sr_d        = 8'hFF;
        bit_index_d = '0;
        if (latch_filt_q) begin
          state_d = ST_LOAD;
          sr_d    = ~buttons_in;
        end
      end
      ST_LOAD: begin
        sr_d        = ~buttons_in;
        bit_index_d = '0;
        if (latch_fall) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (latch_rise) begin
          state_d     = ST_LOAD;
          sr_d        = ~buttons_in;
          bit_index_d = '0;
        end else if (clk_rise) begin
          sr_d        = {sr_q[6:0], 1'b1};
          bit_index_d = bit_index_q + 4'd1;
          if (bit_index_q == 4'd7) begin
            state_d      = ST_DONE;
            sr_d         = 8'hFF;
            read_done_d  = 1'b1;
            read_count_d = read_count_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        sr_d = 8'hFF;
        if (latch_rise) begin
          state_d     = ST_LOAD;
          sr_d        = ~buttons_in;
          bit_index_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sr_d    = 8'hFF;
      end
    endcase
  end

  assign nes_data   = nes_data_q;
  assign bit_index  = bit_index_q;
  assign read_done  = read_done_q;
  assign read_count = read_count_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Bench for nes_pad_responder: directed scenarios plus randomized reads,
// compared against a bit-list model of a 4021-style pad.
module tb_nes_pad_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  buttons_in = 8'h00;
  logic        nes_latch = 1'b0;
  logic        nes_clk = 1'b0;
  logic        nes_data;
  logic [3:0]  bit_index;
  logic        read_done;
  logic [15:0] read_count;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [15:0] exp_count = 16'd0;

  nes_pad_responder #(.SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons_in (buttons_in),
    .nes_latch  (nes_latch),
    .nes_clk    (nes_clk),
    .nes_data   (nes_data),
    .bit_index  (bit_index),
    .read_done  (read_done),
    .read_count (read_count)
  );

  always #10 clk = ~clk;

  // Counts clock cycles during which read_done is high.
  always @(posedge clk) if (read_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clk(input int hi, input int lo);
    nes_clk = 1'b1;
    cycles(hi);
    nes_clk = 1'b0;
    cycles(lo);
  endtask

  task automatic do_latch(input logic [7:0] b);
    buttons_in = b;
    nes_latch  = 1'b1;
    cycles(12);
    nes_latch  = 1'b0;
    cycles(10);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycles(3);
    tests++; if (nes_data !== 1'b1) begin fails++; $display("FAIL reset_nes_data: got %b expected 1", nes_data); end
    tests++; if (bit_index !== 4'd0) begin fails++; $display("FAIL reset_bit_index: got %0d expected 0", bit_index); end
    tests++; if (read_done !== 1'b0) begin fails++; $display("FAIL reset_read_done: got %b expected 0", read_done); end
    tests++; if (read_count !== 16'd0) begin fails++; $display("FAIL reset_read_count: got %0d expected 0", read_count); end
    reset = 1'b1;
    cycles(2);
    exp_count = 16'd0;
  endtask

  task automatic test_full_read();
    logic [7:0] exp_bits;
    int d0;
    d0 = done_cnt;
    buttons_in = 8'b1001_0010;
    exp_bits = 8'b0110_1101;
    nes_latch = 1'b1;
    cycles(600);
    nes_latch = 1'b0;
    cycles(300);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (nes_data !== exp_bits[7-i]) begin
        fails++; $display("FAIL full_read_bit%0d: got %b expected %b", i, nes_data, exp_bits[7-i]);
      end
      pulse_clk(300, 300);
    end
    exp_count = exp_count + 16'd1;
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL full_read_done_pulses: got %0d expected 1", done_cnt - d0); end
    tests++; if (read_count !== exp_count) begin fails++; $display("FAIL full_read_count: got %0d expected %0d", read_count, exp_count); end
    tests++; if (bit_index !== 4'd8) begin fails++; $display("FAIL full_read_bit_index: got %0d expected 8", bit_index); end
    pulse_clk(300, 300);
    tests++; if (nes_data !== 1'b1) begin fails++; $display("FAIL ninth_clock_data: got %b expected 1", nes_data); end
    tests++; if (bit_index !== 4'd8) begin fails++; $display("FAIL ninth_clock_bit_index: got %0d expected 8", bit_index); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL ninth_clock_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_latch_timing();
    int n;
    buttons_in = 8'h80 | 8'($urandom_range(0, 127));
    nes_latch = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      n++;
      if (nes_data === 1'b0) break;
    end
    tests++; if (n != 7) begin fails++; $display("FAIL latch_latency: got %0d cycles expected 7", n); end
    cycles(5);
    nes_latch = 1'b0;
    cycles(10);
  endtask

  task automatic test_glitch();
    logic [7:0] exp_bits;
    exp_bits = ~buttons_in;
    pulse_clk(3, 15);
    tests++; if (bit_index !== 4'd0) begin fails++; $display("FAIL glitch3_bit_index: got %0d expected 0", bit_index); end
    tests++; if (nes_data !== exp_bits[7]) begin fails++; $display("FAIL glitch3_data: got %b expected %b", nes_data, exp_bits[7]); end
    pulse_clk(4, 15);
    tests++; if (bit_index !== 4'd1) begin fails++; $display("FAIL pulse4_bit_index: got %0d expected 1", bit_index); end
    tests++; if (nes_data !== exp_bits[6]) begin fails++; $display("FAIL pulse4_data: got %b expected %b", nes_data, exp_bits[6]); end
  endtask

  task automatic test_abort();
    logic [7:0] b1, b2, exp_bits;
    int d0;
    b1 = 8'($urandom);
    b2 = ~b1;
    d0 = done_cnt;
    do_latch(b1);
    repeat (3) pulse_clk(8, 10);
    tests++; if (bit_index !== 4'd3) begin fails++; $display("FAIL abort_pre_bit_index: got %0d expected 3", bit_index); end
    buttons_in = b2;
    nes_latch = 1'b1;
    cycles(12);
    exp_bits = ~b2;
    tests++; if (bit_index !== 4'd0) begin fails++; $display("FAIL abort_bit_index: got %0d expected 0", bit_index); end
    tests++; if (read_count !== exp_count) begin fails++; $display("FAIL abort_read_count: got %0d expected %0d", read_count, exp_count); end
    tests++; if (nes_data !== exp_bits[7]) begin fails++; $display("FAIL abort_restart_A: got %b expected %b", nes_data, exp_bits[7]); end
    nes_latch = 1'b0;
    cycles(10);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (nes_data !== exp_bits[7-i]) begin
        fails++; $display("FAIL abort_reread_bit%0d: got %b expected %b", i, nes_data, exp_bits[7-i]);
      end
      pulse_clk(8, 10);
    end
    exp_count = exp_count + 16'd1;
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL abort_done_pulses: got %0d expected 1", done_cnt - d0); end
    tests++; if (read_count !== exp_count) begin fails++; $display("FAIL abort_final_count: got %0d expected %0d", read_count, exp_count); end
  endtask

  task automatic test_collision();
    logic [7:0] b, exp_bits;
    b = 8'($urandom);
    exp_bits = ~b;
    do_latch(b);
    repeat (2) pulse_clk(8, 10);
    nes_latch = 1'b1;
    nes_clk   = 1'b1;
    cycles(12);
    tests++; if (bit_index !== 4'd0) begin fails++; $display("FAIL collision_bit_index: got %0d expected 0", bit_index); end
    tests++; if (nes_data !== exp_bits[7]) begin fails++; $display("FAIL collision_data: got %b expected %b", nes_data, exp_bits[7]); end
    nes_clk = 1'b0;
    cycles(8);
    nes_latch = 1'b0;
    cycles(10);
    pulse_clk(8, 10);
    tests++; if (bit_index !== 4'd1) begin fails++; $display("FAIL collision_resume: got %0d expected 1", bit_index); end
    tests++; if (read_count !== exp_count) begin fails++; $display("FAIL collision_count: got %0d expected %0d", read_count, exp_count); end
  endtask

  task automatic test_random();
    logic [7:0] b, exp_bits;
    int nbits, d0;
    for (int it = 0; it < 25; it++) begin
      b = 8'($urandom);
      exp_bits = ~b;
      nbits = $urandom_range(0, 11);
      if (nbits > 8) nbits = 8;
      d0 = done_cnt;
      buttons_in = b;
      nes_latch = 1'b1;
      cycles($urandom_range(5, 20));
      nes_latch = 1'b0;
      cycles($urandom_range(9, 15));
      for (int i = 0; i < nbits; i++) begin
        buttons_in = 8'($urandom);
        if ($urandom_range(0, 3) == 0) pulse_clk($urandom_range(1, 3), 6);
        tests++;
        if (nes_data !== exp_bits[7-i]) begin
          fails++; $display("FAIL rand%0d_bit%0d: got %b expected %b", it, i, nes_data, exp_bits[7-i]);
        end
        pulse_clk($urandom_range(5, 10), $urandom_range(9, 12));
      end
      if (nbits == 8) exp_count = exp_count + 16'd1;
      tests++;
      if (bit_index !== 4'(nbits)) begin
        fails++; $display("FAIL rand%0d_bit_index: got %0d expected %0d", it, bit_index, nbits);
      end
      tests++;
      if (done_cnt - d0 != ((nbits == 8) ? 1 : 0)) begin
        fails++; $display("FAIL rand%0d_done_pulses: got %0d expected %0d", it, done_cnt - d0, (nbits == 8) ? 1 : 0);
      end
      tests++;
      if (read_count !== exp_count) begin
        fails++; $display("FAIL rand%0d_count: got %0d expected %0d", it, read_count, exp_count);
      end
    end
  endtask

  task automatic test_wrap();
    int d0;
    force dut.read_count_q = 16'hFFFF;
    cycles(1);
    release dut.read_count_q;
    cycles(1);
    tests++; if (read_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %0h expected ffff", read_count); end
    d0 = done_cnt;
    do_latch(8'($urandom));
    repeat (8) pulse_clk(6, 10);
    exp_count = 16'd0;
    tests++; if (read_count !== 16'd0) begin fails++; $display("FAIL wrap_count: got %0h expected 0", read_count); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL wrap_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_shift();
    do_latch(8'hFF);
    repeat (3) pulse_clk(8, 10);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    exp_count = 16'd0;
    tests++; if (bit_index !== 4'd0) begin fails++; $display("FAIL midreset_bit_index: got %0d expected 0", bit_index); end
    tests++; if (nes_data !== 1'b1) begin fails++; $display("FAIL midreset_data: got %b expected 1", nes_data); end
    tests++; if (read_count !== 16'd0) begin fails++; $display("FAIL midreset_count: got %0d expected 0", read_count); end
    pulse_clk(8, 10);
    tests++; if (bit_index !== 4'd0) begin fails++; $display("FAIL midreset_idle_clock: got %0d expected 0", bit_index); end
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_latch_timing();
    test_glitch();
    test_abort();
    test_collision();
    test_random();
    test_wrap();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
